// File: rtl/sma_pkg.sv
// Shared definitions for the streaming moving-average filter: accumulator
// width helper and rounding-mode encodings.
package sma_pkg;

  localparam int RND_FLOOR   = 0;
  localparam int RND_HALF_UP = 1;

  // The sum of N = 2**log2_depth samples needs log2_depth extra bits of headroom.
  function automatic int sma_sum_w(input int data_w, input int log2_depth);
    return data_w + log2_depth;
  endfunction

endpackage

// File: rtl/sma_stream_if.sv
// Sample stream into the averager and the averaged stream out of it.
// The filter uses the slave modport; the sample source or host uses master.
interface sma_stream_if #(
  parameter int DATA_W = 16
);

  logic                     clear;
  logic                     x_valid;
  logic signed [DATA_W-1:0] x;
  logic                     y_valid;
  logic signed [DATA_W-1:0] y;
  logic                     full;

  modport master (
    output clear,
    output x_valid,
    output x,
    input  y_valid,
    input  y,
    input  full
  );

  modport slave (
    input  clear,
    input  x_valid,
    input  x,
    output y_valid,
    output y,
    output full
  );

endinterface

// File: rtl/sma_delay_line.sv
// N-entry circular sample buffer. The entry about to be overwritten (the
// oldest sample) is presented combinationally so it can be subtracted the same cycle.
module sma_delay_line #(
  parameter int DATA_W     = 16,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] old
);

  localparam int N = 1 << LOG2_DEPTH;

  logic signed [DATA_W-1:0] mem [N];
  logic [LOG2_DEPTH-1:0]    wr_ptr;

  assign old = mem[wr_ptr];

  // Entries are zeroed explicitly so warm-up averages against zeros, not X.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      for (int i = 0; i < N; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= din;
      wr_ptr      <= wr_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sma_stream.sv
// Streaming simple moving average over the last 2**LOG2_DEPTH accepted samples,
// kept as a running sum (add newest, subtract oldest) with a registered output.
module sma_stream
  import sma_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int LOG2_DEPTH = 2,
  parameter int ROUND      = RND_FLOOR
) (
  input  logic        clk,
  input  logic        rst,
  sma_stream_if.slave s
);

  localparam int N     = 1 << LOG2_DEPTH;
  localparam int SUM_W = sma_sum_w(DATA_W, LOG2_DEPTH);
  localparam int CNT_W = LOG2_DEPTH + 1;

  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);
  localparam logic signed [SUM_W-1:0] RND =
    (ROUND == RND_HALF_UP) ? SUM_W'(N / 2) : '0;

  logic                     accept;
  logic signed [DATA_W-1:0] old;
  logic signed [SUM_W-1:0]  sum;
  logic signed [SUM_W-1:0]  sum_n;
  logic signed [SUM_W-1:0]  sum_rnd;
  logic signed [SUM_W-1:0]  shifted;
  logic [CNT_W-1:0]         fill_cnt;
  logic [CNT_W-1:0]         fill_n;

  logic                     y_valid_q;
  logic signed [DATA_W-1:0] y_q;
  logic                     full_q;

  assign accept = s.x_valid && !s.clear;

  sma_delay_line #(
    .DATA_W     (DATA_W),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_delay_line (
    .clk   (clk),
    .rst   (rst),
    .clear (s.clear),
    .wr_en (accept),
    .din   (s.x),
    .old   (old)
  );

  // Sign-extending casts; SUM_W headroom means neither the sum nor the
  // rounding offset can overflow, and the shifted result always fits DATA_W.
  assign sum_n   = sum + SUM_W'(s.x) - SUM_W'(old);
  assign sum_rnd = sum_n + RND;
  assign shifted = sum_rnd >>> LOG2_DEPTH;
  assign fill_n  = (fill_cnt == N_CNT) ? fill_cnt : fill_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst || s.clear) begin
      sum       <= '0;
      fill_cnt  <= '0;
      y_valid_q <= 1'b0;
      y_q       <= '0;
      full_q    <= 1'b0;
    end else if (accept) begin
      sum       <= sum_n;
      fill_cnt  <= fill_n;
      y_valid_q <= 1'b1;
      y_q       <= shifted[DATA_W-1:0];
      full_q    <= (fill_n == N_CNT);
    end else begin
      y_valid_q <= 1'b0;
    end
  end

  assign s.y_valid = y_valid_q;
  assign s.y       = y_q;
  assign s.full    = full_q;

endmodule

// File: tb/tb_sma_stream.sv
// Drives three filter configurations (N=4 floor, N=4 round-half-up, N=8 floor)
// with the same directed stream and checks them against a window-of-samples model.
module tb_sma_stream;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sma_stream_if #(.DATA_W(16)) if0 ();
  sma_stream_if #(.DATA_W(16)) if1 ();
  sma_stream_if #(.DATA_W(16)) if2 ();

  sma_stream #(.DATA_W(16), .LOG2_DEPTH(2), .ROUND(0)) u_d2_floor (.clk(clk), .rst(rst), .s(if0));
  sma_stream #(.DATA_W(16), .LOG2_DEPTH(2), .ROUND(1)) u_d2_round (.clk(clk), .rst(rst), .s(if1));
  sma_stream #(.DATA_W(16), .LOG2_DEPTH(3), .ROUND(0)) u_d3_floor (.clk(clk), .rst(rst), .s(if2));

  int n_cmp = 0;
  int n_bad = 0;

  // Model: samples accepted since the last reset/clear (only the newest 8 kept).
  int  hist[$];
  int  acc_cnt = 0;
  int  ey[3]  = '{0, 0, 0};
  bit  ev     = 1'b0;
  bit  ef[3]  = '{1'b0, 1'b0, 1'b0};
  int  cfg_l2[3]  = '{2, 2, 3};
  int  cfg_rnd[3] = '{0, 1, 0};

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  // Mean of the last n samples, treating never-written slots as zero.
  function automatic int model_y(input int q[$], input int l2, input int rnd);
    longint s;
    int     n;
    int     first;
    s = 0;
    n = 1 << l2;
    first = (q.size() > n) ? q.size() - n : 0;
    for (int i = first; i < q.size(); i++) s += q[i];
    if (rnd == 0) return int'(floor_div(s, n));
    return int'(floor_div(2 * s + n, 2 * n));
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Per-cycle model update and comparison of all three instances.
  initial begin
    logic r, c, v;
    logic signed [15:0] xs;
    int dy[3];
    int dv[3];
    int df[3];
    forever begin
      @(posedge clk);
      r = rst; c = if0.clear; v = if0.x_valid; xs = if0.x;
      #1;
      if (!r || c) begin
        hist.delete();
        acc_cnt = 0;
        ev = 1'b0;
        for (int k = 0; k < 3; k++) begin
          ey[k] = 0;
          ef[k] = 1'b0;
        end
      end else if (v) begin
        hist.push_back(int'(xs));
        if (hist.size() > 8) void'(hist.pop_front());
        acc_cnt++;
        ev = 1'b1;
        for (int k = 0; k < 3; k++) begin
          ey[k] = model_y(hist, cfg_l2[k], cfg_rnd[k]);
          ef[k] = (acc_cnt >= (1 << cfg_l2[k]));
        end
      end else begin
        ev = 1'b0;
      end
      dy[0] = int'(if0.y); dv[0] = int'(if0.y_valid); df[0] = int'(if0.full);
      dy[1] = int'(if1.y); dv[1] = int'(if1.y_valid); df[1] = int'(if1.full);
      dy[2] = int'(if2.y); dv[2] = int'(if2.y_valid); df[2] = int'(if2.full);
      for (int k = 0; k < 3; k++) begin
        check($sformatf("cfg%0d y", k), dy[k], ey[k]);
        check($sformatf("cfg%0d y_valid", k), dv[k], int'(ev));
        check($sformatf("cfg%0d full", k), df[k], int'(ef[k]));
      end
    end
  end

  // Apply one cycle of inputs to all instances; returns once outputs are settled.
  task automatic step(input bit rst_v, input bit clr, input bit xv, input int xval);
    @(negedge clk);
    rst = rst_v;
    if0.clear = clr; if1.clear = clr; if2.clear = clr;
    if0.x_valid = xv; if1.x_valid = xv; if2.x_valid = xv;
    if0.x = 16'(xval); if1.x = 16'(xval); if2.x = 16'(xval);
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int xval);
    step(1'b1, 1'b0, 1'b1, xval);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int held;
    if0.clear = 1'b0; if1.clear = 1'b0; if2.clear = 1'b0;
    if0.x_valid = 1'b0; if1.x_valid = 1'b0; if2.x_valid = 1'b0;
    if0.x = '0; if1.x = '0; if2.x = '0;

    // Warm-up ramp from reset.
    do_reset();
    check("lit reset y", int'(if0.y), 0);
    send(4);  check("lit y=1", int'(if0.y), 1);
    send(8);  check("lit y=3", int'(if0.y), 3);
    send(12); check("lit y=6", int'(if0.y), 6);
    check("lit full before N", int'(if0.full), 0);
    send(16); check("lit y=10", int'(if0.y), 10);
    check("lit full at N", int'(if0.full), 1);
    check("lit d3 y=5", int'(if2.y), 5);
    check("lit model y=10", ey[0], 10);

    // Full-scale extremes.
    for (int i = 0; i < 8; i++) send(-32768);
    check("lit y=-32768", int'(if0.y), -32768);
    check("lit d3 y=-32768", int'(if2.y), -32768);
    for (int i = 0; i < 4; i++) send(32767);
    check("lit y=32767", int'(if0.y), 32767);
    check("lit round y=32767", int'(if1.y), 32767);

    // Rounding of small values.
    do_reset();
    send(-1);
    check("lit floor -1", int'(if0.y), -1);
    check("lit round -1", int'(if1.y), 0);
    do_reset();
    send(2);
    check("lit round 0.5", int'(if1.y), 1);
    check("lit model round 0.5", ey[1], 1);
    send(0); send(0); send(0);

    // Gaps in x_valid.
    send(40);
    held = int'(if0.y);
    idle();
    check("lit hold y_valid", int'(if0.y_valid), 0);
    check("lit hold y", int'(if0.y), held);
    idle();
    send(20);

    // Clear wins over a simultaneous sample.
    send(100);
    step(1'b1, 1'b1, 1'b1, 100);
    check("lit clear y", int'(if0.y), 0);
    check("lit clear full", int'(if0.full), 0);
    send(8);
    check("lit after clear y=2", int'(if0.y), 2);

    // Single-cycle reset with a sample present.
    send(50); send(60); send(70);
    step(1'b0, 1'b0, 1'b1, 90);
    check("lit rst y", int'(if0.y), 0);
    check("lit rst y_valid", int'(if0.y_valid), 0);
    send(8);
    check("lit after rst y=2", int'(if0.y), 2);
    check("lit after rst full", int'(if0.full), 0);

    // Ramp 1..16 through the 8-deep instance.
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      send(i);
      if (i == 8) check("lit d3 ramp 8", int'(if2.y), 4);
    end
    check("lit d3 ramp 16", int'(if2.y), 12);
    check("lit d2 ramp 16", int'(if0.y), 14);
    check("lit d2 round ramp 16", int'(if1.y), 15);
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
